// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a first-word-fall-through byte FIFO.
// rxd is synchronised, framed by a start/data/stop FSM, and completed bytes are
// pushed into a 2**DEPTH_LOG2 deep FIFO. Framing errors and overruns pulse for
// one cycle; overruns are also latched in overrun_seen until clear_errors.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rxd,
    output logic                rx_fifo_empty,
    output logic [7:0]          rx_fifo_data,
    input  logic                rx_fifo_read,
    output logic [DEPTH_LOG2:0] rx_fifo_count,
    output logic                frame_err,
    output logic                overrun,
    output logic                overrun_seen,
    input  logic                clear_errors
);

    localparam int                 BCNT_W   = $clog2(CLKS_PER_BIT);
    localparam int                 DEPTH    = 2**DEPTH_LOG2;
    localparam logic [BCNT_W-1:0]  BIT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BCNT_W-1:0]  BIT_HALF = BCNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCNT_W-1:0]  BCNT_ONE = BCNT_W'(1);
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  rx_meta;
    logic                  rxs;
    logic [BCNT_W-1:0]     bcnt;
    logic [2:0]            idx;
    logic [7:0]            shreg;
    logic                  bit_end;
    logic                  half_end;
    logic                  cnt_clr;
    logic                  idx_clr;
    logic                  shift_en;
    logic                  push_req;
    logic                  ferr_req;
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [7:0]            mem [DEPTH];
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;
    logic                  ovr_evt;

    assign bit_end  = (bcnt == BIT_LAST);
    assign half_end = (bcnt == BIT_HALF);

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rxs) state_nxt = START;
            START: if (half_end) state_nxt = rxs ? IDLE : DATA;
            DATA:  if (bit_end && idx == 3'd7) state_nxt = STOP;
            STOP:  if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: timer restarts, bit shifts and end-of-frame decisions.
    always_comb begin
        cnt_clr  = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        push_req = 1'b0;
        ferr_req = 1'b0;
        case (state)
            IDLE:  cnt_clr = 1'b1;
            START: if (half_end) begin
                cnt_clr = 1'b1;
                idx_clr = 1'b1;
            end
            DATA:  if (bit_end) begin
                cnt_clr  = 1'b1;
                shift_en = 1'b1;
            end
            STOP:  if (bit_end) begin
                cnt_clr  = 1'b1;
                push_req = rxs;
                ferr_req = !rxs;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            idx   <= 3'd0;
            shreg <= 8'h00;
        end else begin
            bcnt <= cnt_clr ? '0 : bcnt + BCNT_ONE;
            if (idx_clr)       idx <= 3'd0;
            else if (shift_en) idx <= idx + 3'd1;
            if (shift_en) shreg <= {rxs, shreg[7:1]};
        end
    end

    // FIFO flags use the state at the start of the cycle; a full FIFO drops
    // the incoming byte even if a pop happens in the same cycle.
    assign rx_fifo_empty = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                           (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign wr_en         = push_req && !full;
    assign ovr_evt       = push_req && full;
    assign rd_en         = rx_fifo_read && !rx_fifo_empty;
    assign rx_fifo_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign rx_fifo_count = wr_ptr - rd_ptr;

    // FIFO storage; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= shreg;
    end

    // FIFO pointers and error reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            overrun_seen <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            frame_err <= ferr_req;
            overrun   <= ovr_evt;
            if (ovr_evt)           overrun_seen <= 1'b1;
            else if (clear_errors) overrun_seen <= 1'b0;
        end
    end

endmodule
